// File: rtl/drp_pkg.sv
// Shared constants and FSM encoding for the DRP coefficient responder.
package drp_pkg;

    localparam logic [6:0] CTRL_OFFSET = 7'h20;
    localparam int         COMMIT_BIT  = 0;
    localparam int         LAT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } drp_state_e;

endpackage

// File: rtl/coef_bank.sv
// Shadow and active coefficient registers; commit copies shadow to active in one edge.
module coef_bank #(
    parameter int N_COEF = 16,
    parameter int COEF_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_wr_en,
    input  logic [IDX_W-1:0]         i_idx,
    input  logic [COEF_W-1:0]        i_wr_data,
    input  logic                     i_commit,
    output logic [COEF_W-1:0]        o_rd_data,
    output logic [N_COEF*COEF_W-1:0] o_active,
    output logic                     o_update
);

    logic [COEF_W-1:0]        r_shadow [N_COEF];
    logic [N_COEF*COEF_W-1:0] r_active;
    logic                     r_update;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_COEF; k++) begin
                r_shadow[k] <= '0;
            end
            r_active <= '0;
            r_update <= 1'b0;
        end else begin
            r_update <= i_commit;
            if (i_wr_en) begin
                r_shadow[i_idx] <= i_wr_data;
            end
            if (i_commit) begin
                for (int k = 0; k < N_COEF; k++) begin
                    r_active[k*COEF_W +: COEF_W] <= r_shadow[k];
                end
            end
        end
    end

    assign o_rd_data = r_shadow[i_idx];
    assign o_active  = r_active;
    assign o_update  = r_update;

endmodule

// File: rtl/drp_coef_responder.sv
// DRP slave exposing a shadow/active FIR coefficient bank plus a CTRL commit register.
module drp_coef_responder
    import drp_pkg::*;
#(
    parameter int         N_COEF     = 16,
    parameter int         COEF_W     = 16,
    parameter int         RD_LATENCY = 2,
    parameter logic [6:0] BASE_ADDR  = 7'h40
) (
    input  logic                     clk_78MHz_i,
    input  logic                     reset_i,
    input  logic                     den_i,
    input  logic                     dwe_i,
    input  logic [6:0]               daddr_i,
    input  logic [15:0]              di_i,
    output logic [15:0]              do_o,
    output logic                     drdy_o,
    output logic [N_COEF*COEF_W-1:0] coef_o,
    output logic                     coef_update_o,
    output logic                     busy_err_o
);

    localparam int IDX_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = (RD_LATENCY >= 2) ? LAT_W'(RD_LATENCY - 2) : '0;

    drp_state_e       r_state;
    logic [LAT_W-1:0] r_cnt;
    logic             r_we;
    logic [6:0]       r_addr;
    logic [15:0]      r_di;
    logic             r_rel;
    logic             r_drdy;
    logic [7:0]       r_commit_cnt;

    logic             w_accept;
    logic [6:0]       w_off;
    logic             w_is_coef;
    logic             w_is_ctrl;
    logic             w_wr;
    logic             w_commit;
    logic [COEF_W-1:0] w_rd_coef;
    logic [15:0]      w_rdata;

    // r_rel marks the first cycle after reset release, where den_i is refused.
    assign w_accept   = den_i && !r_rel && (r_state != WAIT);
    assign busy_err_o = den_i && !reset_i && (r_rel || (r_state == WAIT));

    always_ff @(posedge clk_78MHz_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_di    <= '0;
            r_rel   <= 1'b1;
            r_drdy  <= 1'b0;
        end else begin
            r_rel  <= 1'b0;
            r_drdy <= 1'b0;
            unique case (r_state)
                IDLE, ACK: begin
                    if (w_accept) begin
                        r_we   <= dwe_i;
                        r_addr <= daddr_i;
                        r_di   <= di_i;
                        r_cnt  <= LAT_INIT;
                        if (RD_LATENCY == 1) begin
                            r_state <= ACK;
                            r_drdy  <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ACK;
                        r_drdy  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_off     = r_addr - BASE_ADDR;
    assign w_is_coef = (w_off < 7'(N_COEF));
    assign w_is_ctrl = (w_off == CTRL_OFFSET);
    assign w_wr      = r_drdy && r_we;
    assign w_commit  = w_wr && w_is_ctrl && r_di[COMMIT_BIT];

    always_ff @(posedge clk_78MHz_i or posedge reset_i) begin
        if (reset_i) begin
            r_commit_cnt <= '0;
        end else if (w_commit) begin
            r_commit_cnt <= r_commit_cnt + 8'd1;
        end
    end

    coef_bank #(
        .N_COEF (N_COEF),
        .COEF_W (COEF_W),
        .IDX_W  (IDX_W)
    ) u_coef_bank (
        .clk_i     (clk_78MHz_i),
        .rst_i     (reset_i),
        .i_wr_en   (w_wr && w_is_coef),
        .i_idx     (w_off[IDX_W-1:0]),
        .i_wr_data (r_di[COEF_W-1:0]),
        .i_commit  (w_commit),
        .o_rd_data (w_rd_coef),
        .o_active  (coef_o),
        .o_update  (coef_update_o)
    );

    always_comb begin
        w_rdata = 16'h0000;
        if (w_is_coef) begin
            w_rdata = 16'(signed'(w_rd_coef));
        end else if (w_is_ctrl) begin
            w_rdata = {8'h00, r_commit_cnt};
        end
    end

    assign drdy_o = r_drdy;
    assign do_o   = (r_drdy && !r_we) ? w_rdata : 16'h0000;

endmodule
